// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button front end: per-channel FSM states,
// default timing constants for a 100 MHz clock and a repeat reload helper.
package button_conditioner_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_WAIT = 2'd1,
      HELD       = 2'd2,
      REL_WAIT   = 2'd3
   } btn_state_e;

   // 5 ms debounce, 250 ms to first repeat, 50 ms between repeats at 100 MHz
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;
   localparam int unsigned DEF_REPEAT_DELAY    = 25_000_000;
   localparam int unsigned DEF_REPEAT_PERIOD   = 5_000_000;

   // Hold counter value loaded after each repeat pulse so that the next pulse
   // lands one period later; a period longer than the delay degrades to the delay.
   function automatic int unsigned repeat_reload(input int unsigned delay,
                                                 input int unsigned period);
      return (period >= delay) ? 0 : delay - period;
   endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// One button channel: polarity fix, 2-flop synchroniser, debounce FSM,
// registered press/release pulses and optional auto-repeat while held.
module button_conditioner_channel
   import button_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter bit          RPT_EN          = 1'b0,
   parameter bit          INV             = 1'b0
) (
   input  logic clk,
   input  logic clr,
   input  logic raw,
   output logic level,
   output logic press,
   output logic rel,
   output logic rpt
);

   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HW = $clog2(REPEAT_DELAY + 1);

   localparam logic [DW-1:0] DB_ONE      = DW'(1);
   localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_ONE    = HW'(1);
   localparam logic [HW-1:0] HOLD_LAST   = HW'(REPEAT_DELAY - 1);
   localparam logic [HW-1:0] HOLD_RELOAD = HW'(repeat_reload(REPEAT_DELAY, REPEAT_PERIOD));

   logic [1:0]    sync_q;
   logic          s;
   btn_state_e    state;
   logic [DW-1:0] db_cnt;
   logic [HW-1:0] hold_cnt;

   assign s = sync_q[1];

   // Two-flop synchroniser on the polarity-corrected pin; reset loads "not pressed"
   // so a button held through reset is debounced as a fresh press.
   always_ff @(posedge clk) begin
      if (clr) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], raw ^ INV};
      end
   end

   // Debounce FSM with hold/repeat timer; every output is a flop.
   always_ff @(posedge clk) begin
      if (clr) begin
         state    <= IDLE;
         db_cnt   <= '0;
         hold_cnt <= '0;
         level    <= 1'b0;
         press    <= 1'b0;
         rel      <= 1'b0;
         rpt      <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout; pulses default low here and are raised
         // by at most one branch below, so each lasts exactly one cycle.
         press <= 1'b0;
         rel   <= 1'b0;
         rpt   <= 1'b0;
         case (state)
            IDLE: begin
               if (s) begin
                  state  <= PRESS_WAIT;
                  db_cnt <= DB_ONE;
               end
            end
            PRESS_WAIT: begin
               if (!s) begin
                  state  <= IDLE;
                  db_cnt <= '0;
               end else if (db_cnt == DB_LAST) begin
                  state    <= HELD;
                  db_cnt   <= '0;
                  hold_cnt <= '0;
                  press    <= 1'b1;
                  level    <= 1'b1;
               end else begin
                  db_cnt <= db_cnt + DB_ONE;
               end
            end
            HELD: begin
               if (!s) begin
                  state  <= REL_WAIT;
                  db_cnt <= DB_ONE;
               end else if (RPT_EN) begin
                  if (hold_cnt == HOLD_LAST) begin
                     rpt      <= 1'b1;
                     hold_cnt <= HOLD_RELOAD;
                  end else begin
                     hold_cnt <= hold_cnt + HOLD_ONE;
                  end
               end
            end
            REL_WAIT: begin
               // hold_cnt is left untouched so a release bounce resumes the cadence
               if (s) begin
                  state  <= HELD;
                  db_cnt <= '0;
               end else if (db_cnt == DB_LAST) begin
                  state  <= IDLE;
                  db_cnt <= '0;
                  rel    <= 1'b1;
                  level  <= 1'b0;
               end else begin
                  db_cnt <= db_cnt + DB_ONE;
               end
            end
            default: begin
               state  <= IDLE;
               db_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// N-channel button front end: one independent conditioning channel per pin
// plus a combined "any button pressed" pulse.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int unsigned         NUM_BTNS        = 3,
   parameter int unsigned         DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned         REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned         REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter logic [NUM_BTNS-1:0] REPEAT_MASK     = NUM_BTNS'(3'b001),
   parameter logic [NUM_BTNS-1:0] INVERT_MASK     = '0
) (
   input  logic                clk,
   input  logic                clr,
   input  logic [NUM_BTNS-1:0] btn_raw,
   output logic [NUM_BTNS-1:0] btn_level,
   output logic [NUM_BTNS-1:0] btn_press,
   output logic [NUM_BTNS-1:0] btn_rel,
   output logic [NUM_BTNS-1:0] btn_rpt,
   output logic                any_press
);

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
      button_conditioner_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD),
         .RPT_EN          (REPEAT_MASK[i]),
         .INV             (INVERT_MASK[i])
      ) u_chan (
         .clk   (clk),
         .clr   (clr),
         .raw   (btn_raw[i]),
         .level (btn_level[i]),
         .press (btn_press[i]),
         .rel   (btn_rel[i]),
         .rpt   (btn_rpt[i])
      );
   end

   // btn_press is already registered, so this adds no path from the pins
   assign any_press = |btn_press;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: a run-length behavioural model
// checked every cycle, directed scenarios with literal timing expectations,
// then randomized pin activity with occasional resets.
module tb_button_conditioner;

   localparam int          NB       = 3;
   localparam int          D        = 4;
   localparam int          RD       = 10;
   localparam int          RP       = 5;
   localparam logic [2:0]  RPT_MASK = 3'b001;
   localparam logic [2:0]  INV_MASK = 3'b010;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic [2:0] btn_raw = INV_MASK;
   logic [2:0] btn_level, btn_press, btn_rel, btn_rpt;
   logic       any_press;

   int checks = 0;
   int errors = 0;

   button_conditioner #(
      .NUM_BTNS        (NB),
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP),
      .REPEAT_MASK     (RPT_MASK),
      .INVERT_MASK     (INV_MASK)
   ) dut (
      .clk       (clk),
      .clr       (clr),
      .btn_raw   (btn_raw),
      .btn_level (btn_level),
      .btn_press (btn_press),
      .btn_rel   (btn_rel),
      .btn_rpt   (btn_rpt),
      .any_press (any_press)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- behavioural model ----------------
   // Accepted level flips once the synchronised sample has disagreed with it
   // for D consecutive clocks. While pressed with no disagreement pending the
   // hold timer advances; it fires at RD cycles after the press, then every RP.
   bit         m_lvl  [NB];
   int         m_run  [NB];
   int         m_hold [NB];
   bit         m_d1   [NB];
   bit         m_d2   [NB];
   logic [2:0] exp_level = '0, exp_press = '0, exp_rel = '0, exp_rpt = '0;
   bit         model_valid = 1'b0;

   task automatic model_step();
      logic [2:0] p;
      bit s;
      p = btn_raw ^ INV_MASK;
      exp_press = '0;
      exp_rel   = '0;
      exp_rpt   = '0;
      for (int ch = 0; ch < NB; ch++) begin
         if (clr) begin
            m_lvl[ch] = 1'b0; m_run[ch] = 0; m_hold[ch] = 0;
            m_d1[ch] = 1'b0; m_d2[ch] = 1'b0;
         end else begin
            s = m_d2[ch];
            if (s != m_lvl[ch]) begin
               m_run[ch]++;
               if (m_run[ch] == D) begin
                  m_lvl[ch] = s;
                  m_run[ch] = 0;
                  if (s) begin
                     exp_press[ch] = 1'b1;
                     m_hold[ch] = 0;
                  end else begin
                     exp_rel[ch] = 1'b1;
                  end
               end
            end else begin
               if (m_lvl[ch] && m_run[ch] == 0 && RPT_MASK[ch]) begin
                  m_hold[ch]++;
                  if (m_hold[ch] == RD) begin
                     exp_rpt[ch] = 1'b1;
                     m_hold[ch] = RD - RP;
                  end
               end
               m_run[ch] = 0;
            end
            m_d2[ch] = m_d1[ch];
            m_d1[ch] = p[ch];
         end
         exp_level[ch] = m_lvl[ch];
      end
      model_valid = 1'b1;
   endtask

   // Model advances on each active edge
   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Compare DUT against the model on every falling edge
   initial forever begin
      @(negedge clk);
      if (model_valid) begin
         check("model_level", 32'(btn_level), 32'(exp_level));
         check("model_press", 32'(btn_press), 32'(exp_press));
         check("model_rel",   32'(btn_rel),   32'(exp_rel));
         check("model_rpt",   32'(btn_rpt),   32'(exp_rpt));
         check("model_any",   32'(any_press), 32'(|exp_press));
      end
   end

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      // 1: reset with all pins inactive
      clr = 1'b1;
      btn_raw = INV_MASK;
      tick(5);
      check("t1_reset_outputs", 32'({btn_level, btn_press, btn_rel, btn_rpt, any_press}), 32'd0);
      clr = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         check("t1_quiet_after_reset", 32'({btn_level, btn_press, btn_rel, btn_rpt, any_press}), 32'd0);
      end

      // 2: clean press on ch0, repeats at press+10, +15, ...; release
      btn_raw[0] = 1'b1;
      for (int i = 1; i <= 33; i++) begin
         @(negedge clk);
         check("t2_press0", 32'(btn_press[0]), 32'(i == 6));
         check("t2_rpt0", 32'(btn_rpt[0]), 32'(i == 16 || i == 21 || i == 26 || i == 31));
         if (i == 5 || i == 6) check("t2_level0", 32'(btn_level[0]), 32'(i == 6));
      end
      btn_raw[0] = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         check("t2_rel0", 32'(btn_rel[0]), 32'(j == 6));
         check("t2_rpt0_release", 32'(btn_rpt[0]), 32'd0);
         check("t2_level0_release", 32'(btn_level[0]), 32'(j < 6));
      end
      tick(4);

      // 3: ch2 3-cycle glitch and ch0 2-cycle release bounce while held
      btn_raw[0] = 1'b1;
      tick(20);
      btn_raw[0] = 1'b0;
      btn_raw[2] = 1'b1;
      tick(2);
      btn_raw[0] = 1'b1;
      tick(1);
      btn_raw[2] = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         check("t3_no_press2", 32'(btn_press[2]), 32'd0);
         check("t3_no_rel0", 32'(btn_rel[0]), 32'd0);
         check("t3_level0_held", 32'(btn_level[0]), 32'd1);
      end
      tick(10);
      btn_raw[0] = 1'b0;
      tick(12);

      // 4: active-low ch1, never repeats
      btn_raw[1] = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         check("t4_press1", 32'(btn_press[1]), 32'(i == 6));
         check("t4_level1", 32'(btn_level[1]), 32'(i >= 6));
      end
      begin
         int rpt1 = 0;
         for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (btn_rpt[1]) rpt1++;
         end
         check("t4_no_rpt1", 32'(rpt1), 32'd0);
      end
      btn_raw[1] = 1'b1;
      tick(10);

      // 5: simultaneous ch0 + ch2
      btn_raw[0] = 1'b1;
      btn_raw[2] = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         check("t5_press", 32'(btn_press), (i == 6) ? 32'h5 : 32'h0);
         check("t5_any", 32'(any_press), 32'(i == 6));
      end
      btn_raw[0] = 1'b0;
      btn_raw[2] = 1'b0;
      tick(10);

      // 6: clr mid-debounce, button kept held through reset
      btn_raw[0] = 1'b1;
      tick(5);
      clr = 1'b1;
      @(negedge clk);
      check("t6_reset_outputs", 32'({btn_level, btn_press, btn_rel, btn_rpt, any_press}), 32'd0);
      clr = 1'b0;
      for (int m = 1; m <= 8; m++) begin
         @(negedge clk);
         check("t6_press_after_reset", 32'(btn_press[0]), 32'(m == 6));
      end
      btn_raw[0] = 1'b0;
      tick(10);

      // Randomized pin activity, model-checked every cycle
      for (int n = 0; n < 250; n++) begin
         int ch;
         int len;
         ch = int'($urandom_range(0, NB - 1));
         if ($urandom_range(0, 39) == 0) begin
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
         end
         btn_raw[ch] = ~btn_raw[ch];
         if (ch == 0 && $urandom_range(0, 3) == 0)
            len = int'($urandom_range(15, 30));
         else
            len = int'($urandom_range(1, 8));
         tick(len);
      end

      btn_raw = INV_MASK;
      tick(20);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
